// File: rtl/chroni_pkg.sv
// Shared constants and types for the chroni output stage.
package chroni_pkg;

  localparam int LB_AW = 11;
  localparam int PAL_N = 16;

  // RGB565 field positions
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/chroni_palette.sv
// RGB565 palette: single write port, registered read port with a blank override.
module chroni_palette #(
  parameter int PAL_N = chroni_pkg::PAL_N
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [$clog2(PAL_N)-1:0]   wr_addr,
  input  logic [15:0]                wr_data,
  input  logic [$clog2(PAL_N)-1:0]   rd_addr,
  input  logic                       rd_clr,
  output logic [15:0]                rd_data
);

  logic [15:0] mem [PAL_N];

  // Entry storage; a write lands at the edge, so a same-edge read sees the old value
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PAL_N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered lookup, forced to black when blanking
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_clr ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/chroni_pixel_out.sv
// chroni output stage: line buffer fetch, MSB-first serializer, palette lookup
// and sync delay matching; every pin sits 2 clocks behind its inputs.
module chroni_pixel_out #(
  parameter int LB_AW = chroni_pkg::LB_AW,
  parameter int PAL_N = chroni_pkg::PAL_N
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic             pf_in,
  input  logic             hs_pol,
  input  logic             vs_pol,
  input  logic             scale_x2,
  input  logic [LB_AW-1:0] lb_base,
  output logic [LB_AW-1:0] lb_rd_addr,
  input  logic [7:0]       lb_rd_data,
  input  logic [3:0]       fg_idx,
  input  logic [3:0]       bg_idx,
  input  logic [3:0]       border_idx,
  input  logic             pal_wr_en,
  input  logic [3:0]       pal_wr_addr,
  input  logic [15:0]      pal_wr_data,
  output logic [4:0]       vga_r,
  output logic [5:0]       vga_g,
  output logic [4:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs
);
  import chroni_pkg::*;

  fetch_state_t state;
  logic [7:0]   shifter;
  logic [2:0]   bit_cnt;
  logic         phase;
  logic         scale_r;
  logic         pix_now;

  logic         hs1, vs1, de1, pf1, pix1;
  logic [3:0]   fg1, bg1, border1;
  logic [3:0]   pal_idx;
  logic [15:0]  pal_q;

  // Fetch FSM: hold byte 0 ready while idle, then reload every 8 pixels
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      shifter    <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      scale_r    <= 1'b0;
      lb_rd_addr <= lb_base;
    end else begin
      case (state)
        ST_IDLE: begin
          lb_rd_addr <= lb_base;
          if (pf_in) begin
            state      <= ST_ACTIVE;
            shifter    <= lb_rd_data;
            lb_rd_addr <= lb_rd_addr + 1'b1;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            scale_r    <= scale_x2;
          end
        end
        ST_ACTIVE: begin
          if (!pf_in) begin
            state <= ST_IDLE;
          end else if (scale_r && !phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (bit_cnt == 3'd7) begin
              shifter    <= lb_rd_data;
              lb_rd_addr <= lb_rd_addr + 1'b1;
              bit_cnt    <= '0;
            end else begin
              shifter <= {shifter[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Current pixel = MSB of the shifter value being loaded this cycle, so the
  // first playfield cycle already carries bit 7 of byte 0 and stays aligned with pf_in
  always_comb begin
    pix_now = 1'b0;
    if (pf_in) begin
      if (state == ST_IDLE) begin
        pix_now = lb_rd_data[7];
      end else if (scale_r && !phase) begin
        pix_now = shifter[7];
      end else if (bit_cnt == 3'd7) begin
        pix_now = lb_rd_data[7];
      end else begin
        pix_now = shifter[6];
      end
    end
  end

  // Stage 1: capture sync, enables, pixel and palette indices together
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      de1     <= 1'b0;
      pf1     <= 1'b0;
      pix1    <= 1'b0;
      fg1     <= '0;
      bg1     <= '0;
      border1 <= '0;
    end else begin
      hs1     <= hs_in;
      vs1     <= vs_in;
      de1     <= de_in;
      pf1     <= pf_in;
      pix1    <= pix_now;
      fg1     <= fg_idx;
      bg1     <= bg_idx;
      border1 <= border_idx;
    end
  end

  // Stage 2 index select: border outside the playfield, else fg/bg by pixel
  always_comb begin
    pal_idx = border1;
    if (pf1) begin
      pal_idx = pix1 ? fg1 : bg1;
    end
  end

  chroni_palette #(
    .PAL_N (PAL_N)
  ) u_palette (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .wr_en   (pal_wr_en),
    .wr_addr (pal_wr_addr),
    .wr_data (pal_wr_data),
    .rd_addr (pal_idx),
    .rd_clr  (!de1),
    .rd_data (pal_q)
  );

  // Stage 2 sync: apply pin polarity alongside the colour lookup
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      vga_hs <= hs_pol;
      vga_vs <= vs_pol;
    end else begin
      vga_hs <= hs1 ^ hs_pol;
      vga_vs <= vs1 ^ vs_pol;
    end
  end

  assign vga_r = pal_q[R_HI:R_LO];
  assign vga_g = pal_q[G_HI:G_LO];
  assign vga_b = pal_q[B_HI:B_LO];

endmodule

// File: doc/chroni_pixel_out.md
Name: chroni_pixel_out

Overview:
- Output stage of chroni, directly downstream of the line buffer read port.
- Fetches one bitmap byte at a time from the line buffer (`rd_addr`/`rd_data`) and serializes it MSB-first into pixels, with optional 2x horizontal scaling.
- Resolves each pixel through a 16-entry RGB565 palette (foreground, background, border) and blanks outside display enable.
- Delay-matches hs/vs to the colour path, so every VGA pin has a fixed 2-cycle latency.

Parameters:
- LB_AW, 11, line buffer byte-address width.
- PAL_N, 16, palette entries (index width = 4).

Ports:
- `vga_clk`  in  1  pixel clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `hs_in`  in  1  raw hsync, active-high pulse.
- `vs_in`  in  1  raw vsync, active-high pulse.
- `de_in`  in  1  display enable (h_de & v_de).
- `pf_in`  in  1  playfield active (h_pf & v_pf).
- `hs_pol`  in  1  1 = invert hsync at the pin.
- `vs_pol`  in  1  1 = invert vsync at the pin.
- `scale_x2`  in  1  1 = each pixel held 2 clocks.
- `lb_base`  in  LB_AW  first byte address of the line to display.
- `lb_rd_addr`  out  LB_AW  line buffer read address.
- `lb_rd_data`  in  8  bitmap byte; registered RAM, valid 1 cycle after address.
- `fg_idx`  in  4  palette index for set bits.
- `bg_idx`  in  4  palette index for clear bits.
- `border_idx`  in  4  palette index for de & !pf.
- `pal_wr_en`  in  1  palette write strobe (already in vga_clk domain).
- `pal_wr_addr`  in  4  palette entry to write.
- `pal_wr_data`  in  16  RGB565 value.
- `vga_r`  out  5  red.
- `vga_g`  out  6  green.
- `vga_b`  out  5  blue.
- `vga_hs`  out  1  hsync at pin polarity.
- `vga_vs`  out  1  vsync at pin polarity.

Behaviour:
- Reset (`reset_n`=0 at a clock edge):
  - Pipeline registers, shifter, counters and all palette entries clear to 0.
  - `lb_rd_addr` <= `lb_base`.
  - `vga_r`/`vga_g`/`vga_b` = 0; `vga_hs` = `hs_pol`; `vga_vs` = `vs_pol`.
  - Reset mid-line drops the line; the next `pf_in` rise starts clean.
- Fetch FSM, states IDLE and ACTIVE:
  - IDLE: `lb_rd_addr` <= `lb_base` every cycle, so `lb_rd_data` holds byte 0 before `pf_in` rises.
  - IDLE->ACTIVE on the first cycle with `pf_in`=1: shifter <= `lb_rd_data`, `lb_rd_addr` <= `lb_rd_addr`+1, bit_cnt <= 0, phase <= 0, `scale_x2` sampled into `scale_r`.
  - `scale_r` holds for the whole line; a `scale_x2` change mid-line takes effect at the next line.
  - ACTIVE, per clock: if `scale_r` and phase==0, then phase <= 1 and hold. Otherwise phase <= 0 and the pixel advances.
  - Pixel advance when bit_cnt==7: reload shifter from `lb_rd_data` and `lb_rd_addr`+1 (wrap mod 2^LB_AW). Otherwise shift left and bit_cnt+1.
  - Byte period is 8 clocks (1x) or 16 clocks (2x). Address settles at least 7 cycles before the next reload.
  - ACTIVE->IDLE on the first cycle with `pf_in`=0. The shifter content is discarded and no further address increment happens.
  - `pf_in` high on consecutive lines with no low gap cannot occur; no recovery is required.
- Pixel pipeline:
  - Stage 1 registers: {`hs_in`, `vs_in`, `de_in`, `pf_in`}, pix = shifter[7] while ACTIVE (0 otherwise), and the indices.
  - Stage 2: index = !de ? none : !pf ? `border_idx` : pix ? `fg_idx` : `bg_idx`.
  - Stage 2 RGB = de ? palette[index] : 0.
  - Stage 2 `vga_hs` = hs ^ `hs_pol`; `vga_vs` = vs ^ `vs_pol`.
  - Latency from any input to pins = 2 clocks, equal for sync, enable and colour.
- Palette:
  - A write lands at the clock edge; a stage-2 lookup of the same entry in the same cycle returns the old value and the next cycle returns the new value.
  - Writes are accepted at any time, including mid-line.
- Boundaries:
  - `lb_rd_addr` wraps 2047->0.
  - `pf_in` with `de_in`=0 outputs black.
  - A 1-cycle `pf_in` pulse emits exactly one pixel (shifter[7] of byte 0).

Decomposition:
- Shared package `chroni_pkg`: RGB565 field slice constants (R 15:11, G 10:5, B 4:0), PAL_N, LB_AW, fetch state encoding (ST_IDLE=0, ST_ACTIVE=1).
- One sub-module: `chroni_palette`, 16x16 register file with a single write port and a registered read port.
- Serializer and delay pipeline stay in the top module.

Test Plan:
- Reset then release: RGB=0, `vga_hs`=`hs_pol`, `vga_vs`=`vs_pol`, `lb_rd_addr`=`lb_base`=640 → pins hold until inputs change.
- 1x line: `lb_base`=0, bytes 0xA5,0xFF, palette[1]=F75B, palette[2]=29AC, `fg_idx`=1, `bg_idx`=2, `pf_in` high 16 clocks → 2 clocks later, pixels F75B,29AC,F75B,29AC,29AC,F75B,29AC,F75B, then 8x F75B. `lb_rd_addr` steps 0,1,2.
- 2x line: same data, `scale_x2`=1, 32 clocks → each pixel doubled; address increments every 16 clocks. `scale_x2` toggled mid-line → no change until the next line.
- Border and blank: `de_in`=1, `pf_in`=0, `border_idx`=3, palette[3]=10A3 → 10A3. `de_in`=0 → 0000. `hs_in` pulse with `hs_pol`=1 → `vga_hs` low exactly 2 clocks after.
- Palette write mid-line: write palette[1]=07E0 on cycle N while showing fg → cycle N shows old F75B, cycle N+1 shows 07E0.
- Wrap and reset: `lb_base`=2046, 3 bytes → addresses 2046,2047,0. `reset_n`=0 mid-line → RGB=0 next cycle, `lb_rd_addr`=`lb_base`; the next line renders from byte 0.
